// File: rtl/myexp2_pkg.sv
// Shared types and elaboration-time helpers for the base-2 antilog block.
// The multiplier constants are the 2^-k roots of 2, expressed in Q1.(mant_w-1).
package myexp2_pkg;

  typedef enum logic [1:0] {IDLE, ITER, SHIFT, DONE} state_t;

  function automatic int idx_width(input int width);
    return $clog2(width);
  endfunction

  // round(2^(2^-k) * 2^(mant_w-1)); only ever evaluated on constants
  function automatic int c_const(input int k, input int mant_w);
    real e;
    real r;
    e = 1.0 / (2.0 ** k);
    r = (2.0 ** e) * (2.0 ** (mant_w - 1));
    return $rtoi(r + 0.5);
  endfunction

endpackage

// File: rtl/myexp2_mul_step.sv
// One fractional-exponent step: m * C scaled back to Q1.(MANT_W-1), or m held.
// Latency: combinational. Backpressure: none, driven by the caller's FSM.
module myexp2_mul_step #(
  parameter int MANT_W = 16
) (
  input  logic [MANT_W-1:0] m,
  input  logic [MANT_W-1:0] c,
  input  logic              en,
  output logic [MANT_W-1:0] m_next
);

  // m stays below 2^MANT_W, so dropping the product's top bits loses nothing
  assign m_next = en ? MANT_W'(({{MANT_W{1'b0}}, m} * {{MANT_W{1'b0}}, c}) >> (MANT_W - 1))
                     : m;

endmodule

// File: rtl/myexp2.sv
// Sequential floor(2^x): one fraction bit per cycle, then shift by the integer part.
// Latency: FRAC_W+2 cycles accept-to-res_valid. Backpressure: DONE holds until res_ready.
module myexp2
  import myexp2_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int FRAC_W    = 8,
  parameter  int MANT_W    = 16,
  localparam int IDX_WIDTH = idx_width(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IDX_WIDTH+FRAC_W-1:0] src,
  input  logic                        src_valid,
  output logic                        src_ready,
  output logic [WIDTH-1:0]            res,
  output logic                        res_valid,
  input  logic                        res_ready
);

  localparam int SRC_W = IDX_WIDTH + FRAC_W;
  localparam int CNT_W = $clog2(FRAC_W + 1);
  localparam logic [MANT_W-1:0] MANT_ONE = MANT_W'(1) << (MANT_W - 1);

  state_t               state_q, state_d;
  logic                 src_ready_d, res_valid_d;
  logic [WIDTH-1:0]     res_d;
  logic [MANT_W-1:0]    m_q, m_d, m_next, c_sel;
  logic [CNT_W-1:0]     k_q, k_d;
  logic [IDX_WIDTH-1:0] ipart_q, ipart_d;
  logic [FRAC_W-1:0]    frac_q, frac_d;
  logic                 step_en;
  logic [MANT_W-1:0]    ctab [FRAC_W];

  for (genvar g = 0; g < FRAC_W; g++) begin : g_ctab
    localparam logic [MANT_W-1:0] CK = MANT_W'(c_const(g + 1, MANT_W));
    assign ctab[g] = CK;
  end

  always_comb begin
    c_sel = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (k_q == CNT_W'(i + 1)) c_sel = ctab[i];
    end
  end

  myexp2_mul_step #(.MANT_W(MANT_W)) u_mul_step (
    .m      (m_q),
    .c      (c_sel),
    .en     (step_en),
    .m_next (m_next)
  );

  always_comb begin
    state_d     = state_q;
    src_ready_d = src_ready;
    res_d       = res;
    res_valid_d = res_valid;
    m_d         = m_q;
    k_d         = k_q;
    ipart_d     = ipart_q;
    frac_d      = frac_q;
    step_en     = 1'b0;
    case (state_q)
      IDLE: begin
        src_ready_d = 1'b1;
        if (src_valid && src_ready) begin
          ipart_d     = src[SRC_W-1:FRAC_W];
          frac_d      = src[FRAC_W-1:0];
          m_d         = MANT_ONE;
          k_d         = CNT_W'(1);
          src_ready_d = 1'b0;
          state_d     = ITER;
        end
      end
      ITER: begin
        // frac is shifted left each step so its MSB is always bit FRAC_W-k
        step_en = frac_q[FRAC_W-1];
        m_d     = m_next;
        frac_d  = frac_q << 1;
        if (k_q == CNT_W'(FRAC_W)) state_d = SHIFT;
        else                       k_d     = k_q + CNT_W'(1);
      end
      SHIFT: begin
        res_d       = WIDTH'(({{WIDTH{1'b0}}, m_q} << ipart_q) >> (MANT_W - 1));
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          src_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_ready <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
      m_q       <= '0;
      k_q       <= '0;
      ipart_q   <= '0;
      frac_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_ready <= src_ready_d;
      res       <= res_d;
      res_valid <= res_valid_d;
      m_q       <= m_d;
      k_q       <= k_d;
      ipart_q   <= ipart_d;
      frac_q    <= frac_d;
    end
  end

endmodule

// File: tb/tb_myexp2.sv
// Directed and random checks of myexp2 against a real-arithmetic floor(2^x) model.
module tb_myexp2;

  localparam int WIDTH  = 32;
  localparam int FRAC_W = 8;
  localparam int MANT_W = 16;
  localparam int SRC_W  = 13;

  logic             clk;
  logic             rst_n;
  logic [SRC_W-1:0] src;
  logic             src_valid;
  logic             src_ready;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             res_ready;

  int     n_cmp = 0;
  int     n_err = 0;
  int     lat;
  longint cref [1:8];
  logic [WIDTH-1:0] held;

  myexp2 #(.WIDTH(WIDTH), .FRAC_W(FRAC_W), .MANT_W(MANT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .res       (res),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mantissa as a chain of truncated multiplies by the rounded 2^(2^-k) constants
  function automatic longint model_m(input logic [SRC_W-1:0] x);
    longint m = 32768;
    for (int k = 1; k <= 8; k++)
      if (x[8-k]) m = (m * cref[k]) / 32768;
    return m;
  endfunction

  function automatic longint model_res(input logic [SRC_W-1:0] x);
    longint p;
    p = model_m(x) * (longint'(1) << x[12:8]);
    return (p / 32768) & 64'hFFFF_FFFF;
  endfunction

  // Presents x, waits for acceptance, then counts cycles until res_valid
  task automatic send(input logic [SRC_W-1:0] x);
    int t = 0;
    @(negedge clk);
    src = x;
    src_valid = 1'b1;
    while (!src_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 64'(t < 50), 64'd1);
    lat = 0;
    @(negedge clk);
    src_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op(input string tag, input logic [SRC_W-1:0] x);
    send(x);
    chk({tag, "_lat"}, 64'(lat), 64'd10);
    chk({tag, "_res"}, 64'(res), 64'(model_res(x)));
  endtask

  initial begin
    for (int k = 1; k <= 8; k++)
      cref[k] = longint'($rtoi($pow(2.0, 1.0 / $pow(2.0, k)) * 32768.0 + 0.5));

    rst_n = 1'b0;
    src = '0;
    src_valid = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_src_ready_lo", 64'(src_ready), 64'd0);
    @(negedge clk);
    chk("rel_src_ready_hi", 64'(src_ready), 64'd1);

    // Directed points with hand-derived answers
    send(13'h0000);
    chk("x0_lat", 64'(lat), 64'd10);
    chk("x0_res", 64'(res), 64'd1);
    send(13'h0300);
    chk("x3_res", 64'(res), 64'd8);
    send(13'h1F00);
    chk("x31_res", 64'(res), 64'h8000_0000);
    send(13'h0480);
    chk("x4p5_res", 64'(res), 64'd22);
    send(13'h00FF);
    chk("xff_res", 64'(res), 64'd1);
    chk("xff_m", 64'(dut.m_q), 64'(model_m(13'h00FF)));
    chk("xff_m_range", 64'(dut.m_q < 17'd65536 && dut.m_q >= 17'd32768), 64'd1);
    op("xmax", 13'h1FFF);

    // Handshake completes on the edge after res_valid&&res_ready
    @(negedge clk);
    chk("idle_res_valid", 64'(res_valid), 64'd0);
    chk("idle_src_ready", 64'(src_ready), 64'd1);

    // Backpressure: DONE must hold and refuse a second operand
    res_ready = 1'b0;
    send(13'h0A40);
    chk("bp_res", 64'(res), 64'(model_res(13'h0A40)));
    held = res;
    src = 13'h0100;
    src_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_res", 64'(res), 64'(held));
      chk("bp_hold_valid", 64'(res_valid), 64'd1);
      chk("bp_src_ready", 64'(src_ready), 64'd0);
    end
    src_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", 64'(res_valid), 64'd0);
    chk("bp_rel_ready", 64'(src_ready), 64'd1);
    chk("bp_rel_res_kept", 64'(res), 64'(held));

    // Reset in the middle of the iteration phase (fourth fraction step)
    @(negedge clk);
    src = 13'h05FF;
    src_valid = 1'b1;
    @(negedge clk);
    src_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_res", 64'(res), 64'd0);
    chk("midrst_src_ready", 64'(src_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(13'h0100);
    chk("after_rst_lat", 64'(lat), 64'd10);
    chk("after_rst_res", 64'(res), 64'd2);

    // Random sweep against the model
    for (int i = 0; i < 1000; i++)
      op("rand", SRC_W'($urandom_range(0, (1 << SRC_W) - 1)));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
